// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder for the
// datapath data-memory port, backed by a synchronous byte-wide RAM.
// Optional feature macro: MEM_ADDR_CHECK_EN (flag addresses >= MEM_DEPTH
// as errors instead of wrapping them).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is only high in IDLE outside reset.
// The response is a single-cycle resp_valid strobe with no backpressure.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [1:0]            state_dbg
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  accept, commit;

    logic                  hold_we;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_wdata;

    // Commit-side view of the request: with zero wait states the commit
    // happens on the accept edge, so the live inputs are used directly.
    logic                  c_we;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic [IDX_W-1:0]      idx;
    logic                  in_range;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign req_ready = (state == IDLE) & ~reset;
    assign state_dbg = state;

    assign c_we    = (state == IDLE) ? req_we    : hold_we;
    assign c_addr  = (state == IDLE) ? req_addr  : hold_addr;
    assign c_wdata = (state == IDLE) ? req_wdata : hold_wdata;
    assign idx     = c_addr[IDX_W-1:0];

`ifdef MEM_ADDR_CHECK_EN
    assign in_range = ({1'b0, c_addr} < (ADDR_WIDTH+1)'(MEM_DEPTH));
`else
    // Upper address bits are ignored: the address wraps modulo MEM_DEPTH.
    logic addr_unused;
    assign addr_unused = ^{1'b0, c_addr};
    assign in_range    = 1'b1;
`endif

    // Next-state, counter and strobe decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        cnt_nxt   = WAIT_INIT;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter, holding registers and registered response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            resp_valid <= commit;
            resp_err   <= commit & ~in_range;
            if (accept) begin
                hold_we    <= req_we;
                hold_addr  <= req_addr;
                hold_wdata <= req_wdata;
            end
            if (commit) begin
                resp_rdata <= (c_we || !in_range) ? '0 : mem[idx];
            end
        end
    end

    // RAM write port; reset on the commit edge suppresses the write.
    always_ff @(posedge clock) begin
        if (!reset && commit && c_we && in_range) begin
            mem[idx] <= c_wdata;
        end
    end

endmodule
